// File: rtl/boot_seq_loader.sv
// boot_seq_loader: copies a boot image from ROM into core memory over dn_*, then pulses execute_enable
module boot_seq_loader #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                READ_LAT   = 1,
    parameter logic [ADDR_W-1:0] LOAD_BASE  = '0,
    parameter int                AUTO_START = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [ADDR_W-1:0] exec_addr_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              dn_wait,
    output logic              dn_go,
    output logic              dn_wr,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_data,
    output logic [ADDR_W-1:0] execute_addr,
    output logic              execute_enable,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, EXEC, DONE} state_t;
    localparam logic [1:0] LAT_MAX = 2'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, len_q, exec_q, idx_nx;
    logic [1:0]        lat_q;
    logic              auto_q, armed, go, lat_done, last;

    assign idx_nx         = idx_q + ADDR_W'(1);
    assign armed          = state_q == IDLE || state_q == DONE;
    assign go             = armed && (start || auto_q);
    assign lat_done       = lat_q == LAT_MAX;
    assign last           = idx_nx == len_q;
    assign dn_go          = state_q == READ || state_q == WRITE;
    assign dn_wr          = state_q == WRITE && !dn_wait;
    assign execute_enable = state_q == EXEC;
    assign done           = state_q == DONE;
    assign execute_addr   = (state_q == EXEC || state_q == DONE) ? exec_q : '0;
    // Address leads by one cycle so the ROM pipeline sees the next index on the edge entering READ
    assign rom_addr       = armed ? '0 : dn_wr ? idx_nx : idx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (go) state_d = (load_len == '0) ? EXEC : READ;
            READ:       if (lat_done) state_d = WRITE;
            WRITE:      if (!dn_wait) state_d = last ? EXEC : READ;
            EXEC:       state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            exec_q  <= '0;
            lat_q   <= '0;
            auto_q  <= AUTO_START != 0;
            dn_addr <= '0;
            dn_data <= '0;
        end else begin
            state_q <= state_d;
            auto_q  <= 1'b0;
            if (go) begin
                len_q  <= load_len;
                exec_q <= exec_addr_in;
                idx_q  <= '0;
                lat_q  <= '0;
            end
            if (state_q == READ) begin
                lat_q <= lat_done ? '0 : lat_q + 2'd1;
                if (lat_done) begin
                    dn_data <= rom_data;
                    dn_addr <= LOAD_BASE + idx_q;
                end
            end
            if (dn_wr) idx_q <= idx_nx;
        end
    end
endmodule
